// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment display scanner.
// - Scans DIGITS digits at SCAN_DIV clocks per digit.
// - Brightness uses PWM on the anodes.
// - Leading zeros can be blanked.
// - New display data is double-buffered, so a frame never shows half-old,
//   half-new digits.
//
// Update handshake (valid/ready):
// - upd_ready is high while no update is pending.
// - A transfer happens on any rising edge where upd_valid && upd_ready.
// - The transfer captures num/dp/blank_lz into a pending buffer.
// - The pending buffer moves into the display registers at the next frame
//   boundary. upd_ready stays low until then.
// - The source may hold upd_valid high while upd_ready is low; the data is
//   ignored until ready returns.
module seg_scan_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100_000,
  parameter int PWM_BITS = 4
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   num,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [PWM_BITS-1:0]   brightness,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  // Scan and PWM counters
  logic [SW-1:0]       slot_q, slot_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  // Pending update buffer
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] pend_num_q, pend_num_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_blz_q, pend_blz_d;

  // Display registers (change only at frame boundaries)
  logic [4*DIGITS-1:0] disp_num_q, disp_num_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                disp_blz_q, disp_blz_d;

  // Registered pad drivers
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  logic                slot_wrap;
  logic                frame_bnd;
  logic                xfer;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_blank;
  logic                any_nz;
  logic [DIGITS-1:0]   blank_vec;
  logic                lit;
  logic [6:0]          glyph;

  assign upd_ready  = ~pend_q;
  assign frame_tick = frame_bnd & rst;
  assign an         = an_q;
  assign seg        = seg_q;

  // Slot, digit and PWM counters; the frame boundary is the double wrap
  always_comb begin
    slot_wrap = (slot_q == SLOT_LAST);
    frame_bnd = slot_wrap && (digit_q == DIGIT_LAST);
    slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
    digit_d   = digit_q;
    if (slot_wrap) begin
      digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
    end
    pwm_d = pwm_q + 1'b1;
  end

  // Update capture into the pending buffer, then promotion at the boundary.
  // A transfer can only happen with nothing pending. A transfer landing on a
  // boundary therefore stays pending until the next boundary.
  always_comb begin
    xfer       = upd_valid && !pend_q;
    pend_d     = pend_q;
    pend_num_d = pend_num_q;
    pend_dp_d  = pend_dp_q;
    pend_blz_d = pend_blz_q;
    disp_num_d = disp_num_q;
    disp_dp_d  = disp_dp_q;
    disp_blz_d = disp_blz_q;
    if (frame_bnd && pend_q) begin
      disp_num_d = pend_num_q;
      disp_dp_d  = pend_dp_q;
      disp_blz_d = pend_blz_q;
      pend_d     = 1'b0;
    end
    if (xfer) begin
      pend_d     = 1'b1;
      pend_num_d = num;
      pend_dp_d  = dp;
      pend_blz_d = blank_lz;
    end
  end

  // Current digit select, leading-zero blanking and anode/segment decode
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    any_nz    = 1'b0;
    blank_vec = '0;
    // Walk from the most significant digit down. A digit is a leading zero
    // when no digit at or above it is nonzero.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      any_nz       = any_nz | (disp_num_q[4*k +: 4] != 4'h0);
      blank_vec[k] = (k != 0) && disp_blz_q && !disp_dp_q[k] && !any_nz;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_q == DW'(k)) begin
        cur_nib = disp_num_q[4*k +: 4];
        cur_dp  = disp_dp_q[k];
      end
    end
    cur_blank = blank_vec[digit_q];
    case (cur_nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
    lit   = (&brightness) || (pwm_q < brightness);
    seg_d = cur_blank ? 8'hFF : {~cur_dp, glyph};
    an_d  = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (lit && !cur_blank && (digit_q == DW'(k))) an_d[k] = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!rst) begin
      slot_q     <= '0;
      digit_q    <= '0;
      pwm_q      <= '0;
      pend_q     <= 1'b0;
      pend_num_q <= '0;
      pend_dp_q  <= '0;
      pend_blz_q <= 1'b0;
      disp_num_q <= '0;
      disp_dp_q  <= '0;
      disp_blz_q <= 1'b0;
      an_q       <= '1;
      seg_q      <= 8'hFF;
    end else begin
      slot_q     <= slot_d;
      digit_q    <= digit_d;
      pwm_q      <= pwm_d;
      pend_q     <= pend_d;
      pend_num_q <= pend_num_d;
      pend_dp_q  <= pend_dp_d;
      pend_blz_q <= pend_blz_d;
      disp_num_q <= disp_num_d;
      disp_dp_q  <= disp_dp_d;
      disp_blz_q <= disp_blz_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

endmodule
